io_timer_pwm: RTL

IO_TIMER_PWM -- requirements
Module: io_timer_pwm

---
 rtl/io_timer_pkg.sv | 38 +++
 rtl/io_timer_cmp_ch.sv | 58 +++++
 rtl/io_timer_pwm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/io_timer_pkg.sv
// Shared register map, source encodings, status bit indices and IO access sizes
// for the io_timer_pwm block.
package io_timer_pkg;

  localparam logic [15:0] OFF_CTRL   = 16'd0;
  localparam logic [15:0] OFF_IRQEN  = 16'd1;
  localparam logic [15:0] OFF_STATUS = 16'd2;
  localparam logic [15:0] OFF_CNT    = 16'd3;
  localparam logic [15:0] OFF_PER    = 16'd4;
  localparam logic [15:0] OFF_CMP0   = 16'd5;
  localparam logic [15:0] WIN_SIZE   = 16'd16;

  typedef enum logic [1:0] {
    SRC_OFF = 2'b00,
    SRC_1K  = 2'b01,
    SRC_1M  = 2'b10,
    SRC_CLK = 2'b11
  } src_e;

  localparam int CTRL_RSTCNT  = 2;
  localparam int CTRL_SRC_LO  = 4;
  localparam int CTRL_ONESHOT = 6;

  localparam int STAT_PER = 0;
  localparam int STAT_CH0 = 1;

  // Access size strobes are one-hot; all-zero means no access this cycle.
  localparam logic [3:0] SZ_BYTE  = 4'b0001;
  localparam logic [3:0] SZ_WORD  = 4'b0010;
  localparam logic [3:0] SZ_DWORD = 4'b0100;

  function automatic logic [3:0] reg_size(input logic [15:0] off, input int width);
    if (off < OFF_CNT) return SZ_BYTE;
    else if (width == 32) return SZ_DWORD;
    else return SZ_WORD;
  endfunction

endpackage

// File: rtl/io_timer_cmp_ch.sv
// One compare channel: Cmp register, compare hit, sticky status flag and,
// when IO_TIMER_PWM_OUT_EN is defined, a registered PWM output.
module io_timer_cmp_ch
  import io_timer_pkg::*;
#(
  parameter int CWidth = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [CWidth-1:0] wdata_i,
  input  logic              clr_i,
  input  logic [CWidth-1:0] cnt_i,
  input  logic              inc_en_i,
  input  logic              run_i,
  output logic [CWidth-1:0] cmp_o,
  output logic              hit_o,
  output logic              flag_o,
  output logic              pwm_o
);

  logic [CWidth-1:0] cmp_q;
  logic              flag_q;
  logic              flag_d;

  assign hit_o  = inc_en_i && (cnt_i == cmp_q);
  // A hit in the same cycle as a W1C clear keeps the flag set.
  assign flag_d = hit_o || (flag_q && !clr_i);
  assign cmp_o  = cmp_q;
  assign flag_o = flag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q  <= '0;
      flag_q <= 1'b0;
    end else if (en_i) begin
      if (wr_i) cmp_q <= wdata_i;
      flag_q <= flag_d;
    end
  end

`ifdef IO_TIMER_PWM_OUT_EN
  logic pwm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_q <= 1'b0;
    else if (en_i) pwm_q <= run_i && (cnt_i < cmp_q);
  end

  assign pwm_o = pwm_q;
`else
  logic unused_run;
  assign unused_run = run_i;
  assign pwm_o      = 1'b0;
`endif

endmodule

// File: rtl/io_timer_pwm.sv
// IO-mapped timer with period wrap, one-shot mode, CChCnt compare channels and
// an interrupt; PWM outputs only exist when IO_TIMER_PWM_OUT_EN is defined.
module io_timer_pwm
  import io_timer_pkg::*;
#(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CWidth    = 16,
  parameter int          CChCnt    = 2
) (
  input  logic              AClkH,
  input  logic              AResetHN,
  input  logic              AClkHEn,
  input  logic [15:0]       AIoAddr,
  input  logic [63:0]       AIoMosi,
  output logic [63:0]       AIoMiso,
  input  logic [3:0]        AIoWrSize,
  input  logic [3:0]        AIoRdSize,
  output logic              AIoAddrAck,
  output logic              AIoAddrErr,
  input  logic              ASync1M,
  input  logic              ASync1K,
  output logic              AIrq,
  output logic [CChCnt-1:0] APwm,
  output logic [7:0]        ATest
);

  logic [15:0] off;
  logic [3:0]  need_size;
  logic        wr_act, rd_act, hit, bad, wr_ok, rd_ok;
  logic        wr_ctrl, wr_irqen, wr_status, wr_cnt, wr_per;

  assign off        = AIoAddr - CAddrBase;
  assign wr_act     = |AIoWrSize;
  assign rd_act     = |AIoRdSize;
  assign need_size  = reg_size(off, CWidth);
  assign hit        = (off < WIN_SIZE) && (wr_act || rd_act);
  assign bad        = (off >= OFF_CMP0 + 16'(CChCnt))
                   || (wr_act && AIoWrSize != need_size)
                   || (rd_act && AIoRdSize != need_size);
  assign AIoAddrAck = hit;
  assign AIoAddrErr = hit && bad;
  assign wr_ok      = hit && !bad && wr_act;
  assign rd_ok      = hit && !bad && rd_act;

  assign wr_ctrl    = wr_ok && off == OFF_CTRL;
  assign wr_irqen   = wr_ok && off == OFF_IRQEN;
  assign wr_status  = wr_ok && off == OFF_STATUS;
  assign wr_cnt     = wr_ok && off == OFF_CNT;
  assign wr_per     = wr_ok && off == OFF_PER;

  src_e              src_q, src_d;
  logic              oneshot_q, oneshot_d;
  logic [CChCnt:0]   irqen_q;
  logic              per_flag_q, per_flag_d;
  logic [CWidth-1:0] cnt_q, cnt_d;
  logic [CWidth-1:0] per_q;
  logic              irq_q;
  logic              inc_en, per_hit;
  logic [CChCnt:0]   status_vec;
  logic [7:0]        status_byte;
  logic [CChCnt-1:0] ch_hit, ch_flag;
  logic [CWidth-1:0] cmp_val [CChCnt];
  logic [63:0]       rdata;
  logic              unused_mosi;

  assign unused_mosi = ^AIoMosi[63:CWidth];

  assign inc_en  = (src_q == SRC_CLK)
                || (src_q == SRC_1M && ASync1M)
                || (src_q == SRC_1K && ASync1K);
  assign per_hit = inc_en && (cnt_q == per_q);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt) cnt_d = AIoMosi[CWidth-1:0];
    else if ((wr_ctrl && AIoMosi[CTRL_RSTCNT]) || src_q == SRC_OFF || per_hit) cnt_d = '0;
    else if (inc_en) cnt_d = cnt_q + CWidth'(1);

    src_d     = src_q;
    oneshot_d = oneshot_q;
    if (wr_ctrl) begin
      src_d     = src_e'(AIoMosi[CTRL_SRC_LO +: 2]);
      oneshot_d = AIoMosi[CTRL_ONESHOT];
    end else if (per_hit && oneshot_q) begin
      src_d = SRC_OFF;
    end

    per_flag_d = per_hit || (per_flag_q && !(wr_status && AIoMosi[STAT_PER]));
  end

  for (genvar gi = 0; gi < CChCnt; gi++) begin : g_ch
    io_timer_cmp_ch #(.CWidth(CWidth)) u_ch (
      .clk_i    (AClkH),
      .rst_ni   (AResetHN),
      .en_i     (AClkHEn),
      .wr_i     (wr_ok && off == OFF_CMP0 + 16'(gi)),
      .wdata_i  (AIoMosi[CWidth-1:0]),
      .clr_i    (wr_status && AIoMosi[STAT_CH0+gi]),
      .cnt_i    (cnt_q),
      .inc_en_i (inc_en),
      .run_i    (src_q != SRC_OFF),
      .cmp_o    (cmp_val[gi]),
      .hit_o    (ch_hit[gi]),
      .flag_o   (ch_flag[gi]),
      .pwm_o    (APwm[gi])
    );
    assign status_vec[STAT_CH0+gi] = ch_flag[gi];
  end

  assign status_vec[STAT_PER] = per_flag_q;
  assign status_byte          = 8'(status_vec);

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      src_q      <= SRC_OFF;
      oneshot_q  <= 1'b0;
      irqen_q    <= '0;
      per_flag_q <= 1'b0;
      cnt_q      <= '0;
      per_q      <= '0;
      irq_q      <= 1'b0;
    end else if (AClkHEn) begin
      src_q      <= src_d;
      oneshot_q  <= oneshot_d;
      per_flag_q <= per_flag_d;
      cnt_q      <= cnt_d;
      // Built from the current status so the request trails the flag by one cycle.
      irq_q      <= |(status_vec & irqen_q);
      if (wr_irqen) irqen_q <= AIoMosi[CChCnt:0];
      if (wr_per)   per_q   <= AIoMosi[CWidth-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata[7:0] = {1'b0, oneshot_q, src_q, 4'b0000};
      OFF_IRQEN:  rdata[7:0] = 8'(irqen_q);
      OFF_STATUS: rdata[7:0] = status_byte;
      OFF_CNT:    rdata[CWidth-1:0] = cnt_q;
      OFF_PER:    rdata[CWidth-1:0] = per_q;
      default: begin
        for (int i = 0; i < CChCnt; i++)
          if (off == OFF_CMP0 + 16'(i)) rdata[CWidth-1:0] = cmp_val[i];
      end
    endcase
    if (!rd_ok) rdata = '0;
  end

  assign AIoMiso = rdata;
  assign AIrq    = irq_q;
  assign ATest   = {AClkH, inc_en, per_hit, ch_hit[0], status_byte[2:0], irq_q};

endmodule
